// File: rtl/rst_table.sv
// Register status table: per architectural register, a pending flag and the ROB tag of its producer.
// Reads are combinational from state; dispatch writes, ROB commits and flush masks update on the clock edge.
module rst_table (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  Rsaddr_rst,
  output logic [4:0]  Rstag_rst,
  output logic        Rsvalid_rst,
  input  logic [4:0]  Rtaddr_rst,
  output logic [4:0]  Rttag_rst,
  output logic        Rtvalid_rst,
  input  logic [4:0]  RB_tag_rst,
  input  logic        RB_valid_rst,
  input  logic [4:0]  Wdata_rst,
  input  logic [4:0]  Waddr_rst,
  input  logic        Wen_rst,
  input  logic [31:0] Wen0_rst,
  output logic        Wen1_rst
);

  logic [31:0]      valid_q, valid_d;
  logic [31:0][4:0] tag_q, tag_d;
  logic             wen1_q, wen1_d;

  // Per entry: flush beats dispatch write, which beats commit clear.
  // A flushed entry keeps its old tag even if a write targeted it.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    for (int i = 1; i < 32; i++) begin
      if (RB_valid_rst && valid_q[i] && (tag_q[i] == RB_tag_rst))
        valid_d[i] = 1'b0;
      if (Wen_rst && (Waddr_rst == 5'(i))) begin
        valid_d[i] = 1'b1;
        tag_d[i]   = Wdata_rst;
      end
      if (Wen0_rst[i]) begin
        valid_d[i] = 1'b0;
        tag_d[i]   = tag_q[i];
      end
    end
    valid_d[0] = 1'b0;
    tag_d[0]   = 5'd0;
  end

  assign wen1_d = Wen_rst && (Waddr_rst != 5'd0) && !Wen0_rst[Waddr_rst];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      tag_q   <= '0;
      wen1_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      wen1_q  <= wen1_d;
    end
  end

  assign Rsvalid_rst = (Rsaddr_rst != 5'd0) && valid_q[Rsaddr_rst];
  assign Rstag_rst   = (Rsaddr_rst != 5'd0) ? tag_q[Rsaddr_rst] : 5'd0;
  assign Rtvalid_rst = (Rtaddr_rst != 5'd0) && valid_q[Rtaddr_rst];
  assign Rttag_rst   = (Rtaddr_rst != 5'd0) ? tag_q[Rtaddr_rst] : 5'd0;
  assign Wen1_rst    = wen1_q;

endmodule

// File: tb/tb_rst_table.sv
// Bench for rst_table: directed vector table for the register-status scenarios,
// then random traffic against an array-based reference model.
module tb_rst_table;
  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  Rsaddr_rst, Rtaddr_rst, RB_tag_rst, Wdata_rst, Waddr_rst;
  logic [4:0]  Rstag_rst, Rttag_rst;
  logic        Rsvalid_rst, Rtvalid_rst, RB_valid_rst, Wen_rst, Wen1_rst;
  logic [31:0] Wen0_rst;

  int checks = 0;
  int errors = 0;

  rst_table dut (
    .clock(clock), .reset(reset),
    .Rsaddr_rst(Rsaddr_rst), .Rstag_rst(Rstag_rst), .Rsvalid_rst(Rsvalid_rst),
    .Rtaddr_rst(Rtaddr_rst), .Rttag_rst(Rttag_rst), .Rtvalid_rst(Rtvalid_rst),
    .RB_tag_rst(RB_tag_rst), .RB_valid_rst(RB_valid_rst),
    .Wdata_rst(Wdata_rst), .Waddr_rst(Waddr_rst), .Wen_rst(Wen_rst),
    .Wen0_rst(Wen0_rst), .Wen1_rst(Wen1_rst)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; Wen_rst = 1'b0; Waddr_rst = '0; Wdata_rst = '0;
    RB_valid_rst = 1'b0; RB_tag_rst = '0; Wen0_rst = '0;
  endtask

  // Read one address on both ports and compare to expected state.
  task automatic rd(input string name, input int a, input int v, input int t);
    Rsaddr_rst = 5'(a); Rtaddr_rst = 5'(a); #1;
    chk({name, " rs valid"}, int'(Rsvalid_rst), v);
    chk({name, " rs tag"},   int'(Rstag_rst),   t);
    chk({name, " rt valid"}, int'(Rtvalid_rst), v);
    chk({name, " rt tag"},   int'(Rttag_rst),   t);
  endtask

  typedef struct {
    logic        wen;  logic [4:0] waddr; logic [4:0] wdata;
    logic        rbv;  logic [4:0] rbtag; logic [31:0] flush;
    logic [4:0]  rsa;  logic [4:0] rta;
    logic        e_rsv; logic [4:0] e_rst; logic e_rtv; logic [4:0] e_rtt; logic e_wen1;
  } vec_t;

  vec_t vt[10];

  // reference model
  bit       mv[32];
  bit [4:0] mt[32];
  bit       mwen1;

  initial begin
    //          wen waddr wdata rbv rbtag flush        rsa rta  rsv rst rtv rtt wen1
    vt[0] = '{1, 5,  17, 0, 0,  32'h0,        5, 5,  1, 17, 1, 17, 1};
    vt[1] = '{1, 9,  17, 0, 0,  32'h0,        5, 9,  1, 17, 1, 17, 1};
    vt[2] = '{0, 0,  0,  1, 3,  32'h0,        5, 9,  1, 17, 1, 17, 0};
    vt[3] = '{0, 0,  0,  1, 17, 32'h0,        5, 9,  0, 17, 0, 17, 0};
    vt[4] = '{1, 5,  17, 0, 0,  32'h0,        5, 9,  1, 17, 0, 17, 1};
    vt[5] = '{1, 5,  20, 1, 17, 32'h0,        5, 9,  1, 20, 0, 17, 1};
    vt[6] = '{1, 0,  4,  0, 0,  32'h0,        0, 5,  0, 0,  1, 20, 0};
    vt[7] = '{1, 3,  6,  0, 0,  32'h0,        3, 7,  1, 6,  0, 0,  1};
    vt[8] = '{1, 7,  8,  0, 0,  32'h0,        3, 7,  1, 6,  1, 8,  1};
    vt[9] = '{1, 7,  11, 0, 0,  32'h88,       3, 7,  0, 6,  0, 8,  0};

    idle(); Rsaddr_rst = '0; Rtaddr_rst = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset wen1", int'(Wen1_rst), 0);
    for (int a = 0; a < 32; a++) rd($sformatf("reset reg%0d", a), a, 0, 0);

    // directed table: drive inputs, one edge, then read back
    for (int k = 0; k < 10; k++) begin
      idle();
      Wen_rst = vt[k].wen; Waddr_rst = vt[k].waddr; Wdata_rst = vt[k].wdata;
      RB_valid_rst = vt[k].rbv; RB_tag_rst = vt[k].rbtag; Wen0_rst = vt[k].flush;
      @(posedge clock); #1;
      idle();
      Rsaddr_rst = vt[k].rsa; Rtaddr_rst = vt[k].rta; #1;
      chk($sformatf("vec%0d wen1", k),     int'(Wen1_rst),    int'(vt[k].e_wen1));
      chk($sformatf("vec%0d rs valid", k), int'(Rsvalid_rst), int'(vt[k].e_rsv));
      chk($sformatf("vec%0d rs tag", k),   int'(Rstag_rst),   int'(vt[k].e_rst));
      chk($sformatf("vec%0d rt valid", k), int'(Rtvalid_rst), int'(vt[k].e_rtv));
      chk($sformatf("vec%0d rt tag", k),   int'(Rttag_rst),   int'(vt[k].e_rtt));
    end

    // wen1 lasts exactly one cycle; reads before the edge show old state
    idle(); Wen_rst = 1'b1; Waddr_rst = 5'd12; Wdata_rst = 5'd9;
    Rsaddr_rst = 5'd12; Rtaddr_rst = 5'd12; #1;
    chk("no bypass rs valid", int'(Rsvalid_rst), 0);
    @(posedge clock); #1; idle();
    chk("pulse wen1 high", int'(Wen1_rst), 1);
    rd("reg12 written", 12, 1, 9);
    @(posedge clock); #1;
    chk("pulse wen1 low", int'(Wen1_rst), 0);

    // reset mid-operation overrides a concurrent write
    Wen_rst = 1'b1; Waddr_rst = 5'd20; Wdata_rst = 5'd1; reset = 1'b1;
    @(posedge clock); #1; idle();
    chk("midreset wen1", int'(Wen1_rst), 0);
    for (int a = 0; a < 32; a++) rd($sformatf("midreset reg%0d", a), a, 0, 0);

    // random traffic against the model
    for (int a = 0; a < 32; a++) begin mv[a] = 0; mt[a] = 0; end
    mwen1 = 0;
    for (int c = 0; c < 400; c++) begin
      bit       nv[32];
      bit [4:0] nt[32];
      idle();
      reset        = ($urandom_range(0, 49) == 0);
      Wen_rst      = $urandom_range(0, 2) != 0;
      Waddr_rst    = 5'($urandom_range(0, 31));
      Wdata_rst    = 5'($urandom_range(0, 7));
      RB_valid_rst = $urandom_range(0, 1);
      RB_tag_rst   = 5'($urandom_range(0, 7));
      Wen0_rst     = ($urandom_range(0, 5) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
      Rsaddr_rst   = 5'($urandom_range(0, 31));
      Rtaddr_rst   = 5'($urandom_range(0, 31));
      #1;
      chk("rand rs valid", int'(Rsvalid_rst), int'(mv[Rsaddr_rst]));
      chk("rand rs tag",   int'(Rstag_rst),   int'(mt[Rsaddr_rst]));
      chk("rand rt valid", int'(Rtvalid_rst), int'(mv[Rtaddr_rst]));
      chk("rand rt tag",   int'(Rttag_rst),   int'(mt[Rttag_rst === 5'bx ? 0 : Rtaddr_rst]));
      chk("rand wen1",     int'(Wen1_rst),    int'(mwen1));
      for (int a = 0; a < 32; a++) begin
        nv[a] = mv[a]; nt[a] = mt[a];
        if (RB_valid_rst && mv[a] && mt[a] == RB_tag_rst) nv[a] = 0;
        if (Wen_rst && a != 0 && int'(Waddr_rst) == a && !Wen0_rst[a]) begin
          nv[a] = 1; nt[a] = Wdata_rst;
        end
        if (Wen0_rst[a]) nv[a] = 0;
        if (reset) begin nv[a] = 0; nt[a] = 0; end
      end
      mwen1 = !reset && Wen_rst && Waddr_rst != 0 && !Wen0_rst[Waddr_rst];
      for (int a = 0; a < 32; a++) begin mv[a] = nv[a]; mt[a] = nt[a]; end
      @(posedge clock); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
